avst_pkt_tx: RTL
================

Name: avst_pkt_tx

Overview:
Store-and-forward Avalon-ST packet transmitter. It is the source-side counterpart of the sort block's sink. It loads one packet per pass through a simple word-write port into an internal buffer. Once the packet is complete, it emits the packet on an Avalon-ST source with full backpressure support. It is used to feed main_sort (and similar packet sinks) from control logic in hardware, replacing the bench-only TX driver.

Parameters:
DWIDTH, 8, data word width in bits
MAX_PKT_LEN, 32, maximum words per packet; buffer depth (>=2)

Ports:
clk_i  input  1  clock
arst_n_i  input  1  asynchronous active-low reset
wr_data_i  input  DWIDTH  load word
wr_valid_i  input  1  load word valid
wr_last_i  input  1  load word is last of packet
wr_ready_o  output  1  load port ready (high only in LOAD state)
src_data_o  output  DWIDTH  Avalon-ST data
src_startofpacket_o  output  1  first word of packet
src_endofpacket_o  output  1  last word of packet
src_valid_o  output  1  Avalon-ST valid
src_ready_i  input  1  Avalon-ST ready from sink
trunc_o  output  1  one-cycle pulse: packet truncated at MAX_PKT_LEN

Behaviour:
- Reset is asynchronous and active-low. While arst_n_i=0: state=LOAD, all counters 0, wr_ready_o=0, src_*_o=0, trunc_o=0. wr_ready_o rises on the first clk_i edge after release. Any partial packet (load or send) is discarded.
- States: LOAD, PREP, SEND.
- LOAD:
  - wr_ready_o=1. Each wr_valid_i&wr_ready_o writes buf[wr_cnt] and increments wr_cnt.
  - Accepted word with wr_last_i=1 -> PREP. Packet length len = wr_cnt+1.
  - Accepted word at wr_cnt=MAX_PKT_LEN-1 with wr_last_i=0 -> PREP with len=MAX_PKT_LEN, and trunc_o=1 for one cycle.
  - wr_valid_i gaps are allowed, with no timeout.
- PREP: one cycle. Issues RAM read of address 0, wr_ready_o=0 -> SEND.
- SEND:
  - Latency: src_valid_o rises exactly 2 cycles after the clock edge that accepted the last load word.
  - Word k on src_data_o: src_startofpacket_o=(k==0), src_endofpacket_o=(k==len-1). A 1-word packet asserts sop and eop together.
  - Transfer occurs on src_valid_o&src_ready_i. src_valid_o never drops mid-packet.
  - While src_ready_i=0, data, sop and eop hold stable.
  - Next word is presented the cycle after each transfer, giving one word per cycle under continuous ready. This requires a registered output plus a read-ahead skid so RAM read latency costs no bubbles.
  - Transfer of the eop word -> LOAD. src_valid_o=0 and wr_ready_o=1 on the next cycle.
- Load and send never overlap (single buffer). wr_valid_i outside LOAD is ignored and not written.
- Counters are $clog2(MAX_PKT_LEN+1) bits wide. There is no wrap-around: the LOAD word count saturates by forcing PREP.
- src_ready_i is ignored when src_valid_o=0.

Decomposition:
- Package avst_pkt_pkg holds:
  - state enum (LOAD, PREP, SEND);
  - localparam helper for counter/address width.
- One sub-module, avst_pkt_ram: simple dual-port RAM, 1 write port, 1 read port, registered read (1-cycle latency), DWIDTH x MAX_PKT_LEN, no reset on contents.
- FSM, counters and output skid stay in avst_pkt_tx.

Test Plan:
- Single word 8'hA5 with last, src_ready_i=1 -> one beat: data A5, sop=1, eop=1, 2 cycles after load. wr_ready_o high 1 cycle after the beat.
- Load 5 words 01..05, src_ready_i=1 -> 5 consecutive beats 01..05. sop on 01, eop on 05, no bubbles.
- Same 5 words with src_ready_i randomly low 60% of cycles -> identical beat sequence. Data/sop/eop stable across every stall.
- Load 40 words, none with last, MAX_PKT_LEN=32 -> trunc_o pulses once. 32 beats sent (words 0..31), eop on word 31. Words 32..39 are not accepted during SEND.
- arst_n_i asserted in SEND after 3 of 10 beats -> outputs 0 immediately. After release, a fresh 2-word packet transmits correctly with sop on its first word.
- Chain into main_sort: 10 random packets of lengths 2..32 -> main_sort output equals the sorted input of each packet.

Source files
------------

// File: rtl/avst_pkt_pkg.sv
// Shared types and width helpers for the store-and-forward Avalon-ST packet transmitter.
package avst_pkt_pkg;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        PREP = 2'd1,
        SEND = 2'd2
    } state_e;

    // Counters must hold the value MAX_PKT_LEN itself (packet length), hence +1.
    function automatic int cnt_width(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    function automatic int addr_width(input int max_len);
        return (max_len > 1) ? $clog2(max_len) : 1;
    endfunction

endpackage

// File: rtl/avst_pkt_ram.sv
// Packet buffer: one write port, one registered read port, contents not reset.
module avst_pkt_ram
    import avst_pkt_pkg::*;
#(
    parameter int DWIDTH = 8,
    parameter int DEPTH  = 32,
    parameter int AW     = addr_width(DEPTH)
) (
    input  logic              clk_i,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DWIDTH-1:0] wr_data,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [DWIDTH-1:0] rd_data
);

    logic [DWIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/avst_pkt_tx.sv
// Loads one packet into a buffer through a word-write port, then emits it on an
// Avalon-ST source with a registered output and a one-entry read-ahead skid.
module avst_pkt_tx
    import avst_pkt_pkg::*;
#(
    parameter int DWIDTH      = 8,
    parameter int MAX_PKT_LEN = 32
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic [DWIDTH-1:0] wr_data_i,
    input  logic              wr_valid_i,
    input  logic              wr_last_i,
    output logic              wr_ready_o,
    output logic [DWIDTH-1:0] src_data_o,
    output logic              src_startofpacket_o,
    output logic              src_endofpacket_o,
    output logic              src_valid_o,
    input  logic              src_ready_i,
    output logic              trunc_o
);

    localparam int CW = cnt_width(MAX_PKT_LEN);
    localparam int AW = addr_width(MAX_PKT_LEN);

    state_e state_q, state_d;

    logic [CW-1:0]     wr_cnt, len, rd_addr, rd_idx;
    logic              rd_pending, wr_ready_q, trunc_q;
    logic [DWIDTH-1:0] ram_q, skid_data, out_data;
    logic              skid_valid, skid_sop, skid_eop;
    logic              out_valid, out_sop, out_eop;

    logic              wr_fire, wr_full, wr_end, src_fire, rd_issue, rd_sop, rd_eop;
    logic [1:0]        occ_next;

    assign wr_fire  = wr_ready_q & wr_valid_i;
    assign wr_full  = (wr_cnt == CW'(MAX_PKT_LEN - 1));
    assign wr_end   = wr_fire & (wr_last_i | wr_full);
    assign src_fire = out_valid & src_ready_i;
    assign rd_sop   = (rd_idx == '0);
    assign rd_eop   = (rd_idx == len - CW'(1));

    // Words held or in flight after this edge; a new read is only issued when its
    // result is guaranteed a slot (output register or skid) next cycle.
    assign occ_next = 2'(out_valid) + 2'(skid_valid) + 2'(rd_pending) - 2'(src_fire);
    assign rd_issue = (state_q == PREP) |
                      ((state_q == SEND) & (occ_next < 2'd2) & (rd_addr < len));

    avst_pkt_ram #(
        .DWIDTH (DWIDTH),
        .DEPTH  (MAX_PKT_LEN),
        .AW     (AW)
    ) u_ram (
        .clk_i   (clk_i),
        .wr_en   (wr_fire),
        .wr_addr (wr_cnt[AW-1:0]),
        .wr_data (wr_data_i),
        .rd_en   (rd_issue),
        .rd_addr (rd_addr[AW-1:0]),
        .rd_data (ram_q)
    );

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) state_q <= LOAD;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD:    if (wr_end) state_d = PREP;
            PREP:    state_d = SEND;
            SEND:    if (src_fire && out_eop) state_d = LOAD;
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            wr_cnt     <= '0;
            len        <= '0;
            rd_addr    <= '0;
            rd_idx     <= '0;
            rd_pending <= 1'b0;
            wr_ready_q <= 1'b0;
            trunc_q    <= 1'b0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            skid_sop   <= 1'b0;
            skid_eop   <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_sop    <= 1'b0;
            out_eop    <= 1'b0;
        end else begin
            wr_ready_q <= (state_d == LOAD);
            trunc_q    <= wr_fire & wr_full & ~wr_last_i;

            if (wr_fire) begin
                if (wr_end) begin
                    len    <= wr_cnt + CW'(1);
                    wr_cnt <= '0;
                end else begin
                    wr_cnt <= wr_cnt + CW'(1);
                end
            end

            rd_pending <= rd_issue;
            if (rd_issue) begin
                rd_idx  <= rd_addr;
                rd_addr <= rd_addr + CW'(1);
            end

            if (state_q == SEND) begin
                if (!out_valid || src_fire) begin
                    if (skid_valid) begin
                        out_valid  <= 1'b1;
                        out_data   <= skid_data;
                        out_sop    <= skid_sop;
                        out_eop    <= skid_eop;
                        skid_valid <= rd_pending;
                        skid_data  <= ram_q;
                        skid_sop   <= rd_sop;
                        skid_eop   <= rd_eop;
                    end else if (rd_pending) begin
                        out_valid <= 1'b1;
                        out_data  <= ram_q;
                        out_sop   <= rd_sop;
                        out_eop   <= rd_eop;
                    end else begin
                        out_valid <= 1'b0;
                    end
                end else if (rd_pending) begin
                    skid_valid <= 1'b1;
                    skid_data  <= ram_q;
                    skid_sop   <= rd_sop;
                    skid_eop   <= rd_eop;
                end

                if (src_fire && out_eop) begin
                    out_valid  <= 1'b0;
                    out_sop    <= 1'b0;
                    out_eop    <= 1'b0;
                    skid_valid <= 1'b0;
                    rd_pending <= 1'b0;
                    rd_addr    <= '0;
                end
            end
        end
    end

    assign wr_ready_o          = wr_ready_q;
    assign trunc_o             = trunc_q;
    assign src_valid_o         = out_valid;
    assign src_data_o          = out_data;
    assign src_startofpacket_o = out_sop;
    assign src_endofpacket_o   = out_eop;

endmodule
